// File: rtl/axi4lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write port between NREQ requesters.
// One write is in flight at a time; the read channel is permanently tied off.
module axi4lite_wr_arbiter #(
   parameter int NREQ  = 2,
   parameter int ADDRW = 8,
   parameter int DATAW = 32,
   localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int SW   = DATAW / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*ADDRW-1:0] req_addr_i,
   input  logic [NREQ*DATAW-1:0] req_data_i,
   input  logic [NREQ*SW-1:0]    req_strb_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic [NREQ-1:0]       rsp_valid_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output logic [GW-1:0]         grant_o,
   output logic [ADDRW-1:0]      s_axi_CTRL_AWADDR,
   output logic                  s_axi_CTRL_AWVALID,
   input  logic                  s_axi_CTRL_AWREADY,
   output logic [DATAW-1:0]      s_axi_CTRL_WDATA,
   output logic [SW-1:0]         s_axi_CTRL_WSTRB,
   output logic                  s_axi_CTRL_WVALID,
   input  logic                  s_axi_CTRL_WREADY,
   input  logic [1:0]            s_axi_CTRL_BRESP,
   input  logic                  s_axi_CTRL_BVALID,
   output logic                  s_axi_CTRL_BREADY,
   output logic [ADDRW-1:0]      s_axi_CTRL_ARADDR,
   output logic                  s_axi_CTRL_ARVALID,
   input  logic                  s_axi_CTRL_ARREADY,
   input  logic [DATAW-1:0]      s_axi_CTRL_RDATA,
   input  logic [1:0]            s_axi_CTRL_RRESP,
   input  logic                  s_axi_CTRL_RVALID,
   output logic                  s_axi_CTRL_RREADY
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_DATA = 2'd1,
      RESP      = 2'd2
   } state_t;

   state_t            state_r, state_n;
   logic [ADDRW-1:0]  awaddr_r, awaddr_n;
   logic [DATAW-1:0]  wdata_r, wdata_n;
   logic [SW-1:0]     wstrb_r, wstrb_n;
   logic              awvalid_r, awvalid_n;
   logic              wvalid_r, wvalid_n;
   logic              bready_r, bready_n;
   logic [GW-1:0]     grant_r, grant_n;
   logic [GW-1:0]     last_grant_r, last_grant_n;
   logic [NREQ-1:0]   req_ready_r, req_ready_n;
   logic [NREQ-1:0]   rsp_valid_r, rsp_valid_n;
   logic              rsp_err_r, rsp_err_n;

   logic              found_s;
   logic [GW-1:0]     sel_s;
   logic [GW-1:0]     idx_s;
   logic              aw_done_s;
   logic              w_done_s;
   logic              unused_s;

   function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] k);
      logic [NREQ-1:0] v;
      v    = {NREQ{1'b0}};
      v[k] = 1'b1;
      return v;
   endfunction

   // Round-robin search starting one above the most recent grant
   always_comb begin
      found_s = 1'b0;
      sel_s   = {GW{1'b0}};
      idx_s   = {GW{1'b0}};
      for (int i = 1; i <= NREQ; i++) begin
         idx_s = GW'((int'(last_grant_r) + i) % NREQ);
         if (!found_s && req_valid_i[idx_s]) begin
            found_s = 1'b1;
            sel_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign aw_done_s = !awvalid_r || s_axi_CTRL_AWREADY;
   assign w_done_s  = !wvalid_r || s_axi_CTRL_WREADY;

   // Next-state and next-output logic; ready/response pulses default low
   always_comb begin
      state_n      = state_r;
      awaddr_n     = awaddr_r;
      wdata_n      = wdata_r;
      wstrb_n      = wstrb_r;
      awvalid_n    = awvalid_r;
      wvalid_n     = wvalid_r;
      bready_n     = bready_r;
      grant_n      = grant_r;
      last_grant_n = last_grant_r;
      req_ready_n  = {NREQ{1'b0}};
      rsp_valid_n  = {NREQ{1'b0}};
      rsp_err_n    = 1'b0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               awaddr_n    = req_addr_i[sel_s*ADDRW +: ADDRW];
               wdata_n     = req_data_i[sel_s*DATAW +: DATAW];
               wstrb_n     = req_strb_i[sel_s*SW +: SW];
               awvalid_n   = 1'b1;
               wvalid_n    = 1'b1;
               grant_n     = sel_s;
               req_ready_n = onehot(sel_s);
               state_n     = ADDR_DATA;
            end else begin
               state_n = IDLE;
            end
         end
         ADDR_DATA: begin
            awvalid_n = awvalid_r && !s_axi_CTRL_AWREADY;
            wvalid_n  = wvalid_r && !s_axi_CTRL_WREADY;
            if (aw_done_s && w_done_s) begin
               bready_n = 1'b1;
               state_n  = RESP;
            end else begin
               state_n = ADDR_DATA;
            end
         end
         RESP: begin
            if (s_axi_CTRL_BVALID && bready_r) begin
               bready_n     = 1'b0;
               rsp_valid_n  = onehot(grant_r);
               rsp_err_n    = (s_axi_CTRL_BRESP != 2'b00);
               last_grant_n = grant_r;
               state_n      = IDLE;
            end else begin
               state_n = RESP;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any in-flight write
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         awaddr_r     <= {ADDRW{1'b0}};
         wdata_r      <= {DATAW{1'b0}};
         wstrb_r      <= {SW{1'b0}};
         awvalid_r    <= 1'b0;
         wvalid_r     <= 1'b0;
         bready_r     <= 1'b0;
         grant_r      <= {GW{1'b0}};
         last_grant_r <= GW'(NREQ - 1);
         req_ready_r  <= {NREQ{1'b0}};
         rsp_valid_r  <= {NREQ{1'b0}};
         rsp_err_r    <= 1'b0;
      end else begin
         state_r      <= state_n;
         awaddr_r     <= awaddr_n;
         wdata_r      <= wdata_n;
         wstrb_r      <= wstrb_n;
         awvalid_r    <= awvalid_n;
         wvalid_r     <= wvalid_n;
         bready_r     <= bready_n;
         grant_r      <= grant_n;
         last_grant_r <= last_grant_n;
         req_ready_r  <= req_ready_n;
         rsp_valid_r  <= rsp_valid_n;
         rsp_err_r    <= rsp_err_n;
      end
   end

   assign req_ready_o        = req_ready_r;
   assign rsp_valid_o        = rsp_valid_r;
   assign rsp_err_o          = rsp_err_r;
   assign busy_o             = (state_r != IDLE);
   assign grant_o            = grant_r;
   assign s_axi_CTRL_AWADDR  = awaddr_r;
   assign s_axi_CTRL_AWVALID = awvalid_r;
   assign s_axi_CTRL_WDATA   = wdata_r;
   assign s_axi_CTRL_WSTRB   = wstrb_r;
   assign s_axi_CTRL_WVALID  = wvalid_r;
   assign s_axi_CTRL_BREADY  = bready_r;

   // Write-only master: the read channel never issues a request
   assign s_axi_CTRL_ARADDR  = {ADDRW{1'b0}};
   assign s_axi_CTRL_ARVALID = 1'b0;
   assign s_axi_CTRL_RREADY  = 1'b0;
   assign unused_s = ^{s_axi_CTRL_ARREADY, s_axi_CTRL_RDATA, s_axi_CTRL_RRESP, s_axi_CTRL_RVALID};

endmodule

// File: tb/tb_axi4lite_wr_arbiter.sv
// Table-driven bench for axi4lite_wr_arbiter: one record per write transaction,
// plus a hand-written mid-transaction reset sequence.
module tb_axi4lite_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_addr = 16'h0000;
   logic [63:0] req_data = 64'h0;
   logic [7:0]  req_strb = 8'h00;
   logic [1:0]  req_ready_o, rsp_valid_o;
   logic        rsp_err_o, busy_o;
   logic [0:0]  grant_o;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   int checks = 0;
   int errors = 0;
   int rdy_cnt0 = 0, rdy_cnt1 = 0, rsp_cnt0 = 0, rsp_cnt1 = 0, rd_bad = 0;

   always #5 clk = ~clk;

   axi4lite_wr_arbiter #(.NREQ(2), .ADDRW(8), .DATAW(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data), .req_strb_i(req_strb),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
      .busy_o(busy_o), .grant_o(grant_o),
      .s_axi_CTRL_AWADDR(awaddr), .s_axi_CTRL_AWVALID(awvalid), .s_axi_CTRL_AWREADY(awready),
      .s_axi_CTRL_WDATA(wdata), .s_axi_CTRL_WSTRB(wstrb), .s_axi_CTRL_WVALID(wvalid),
      .s_axi_CTRL_WREADY(wready),
      .s_axi_CTRL_BRESP(bresp), .s_axi_CTRL_BVALID(bvalid), .s_axi_CTRL_BREADY(bready),
      .s_axi_CTRL_ARADDR(araddr), .s_axi_CTRL_ARVALID(arvalid), .s_axi_CTRL_ARREADY(1'b0),
      .s_axi_CTRL_RDATA(32'h0), .s_axi_CTRL_RRESP(2'b00), .s_axi_CTRL_RVALID(1'b0),
      .s_axi_CTRL_RREADY(rready)
   );

   typedef struct {
      logic [1:0]  mask;
      logic        hold;
      int          grant;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      logic [1:0]  bresp;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   // Pulse counters and read-channel watch over the whole run
   always @(negedge clk) begin
      rdy_cnt0 <= rdy_cnt0 + int'(req_ready_o[0]);
      rdy_cnt1 <= rdy_cnt1 + int'(req_ready_o[1]);
      rsp_cnt0 <= rsp_cnt0 + int'(rsp_valid_o[0]);
      rsp_cnt1 <= rsp_cnt1 + int'(rsp_valid_o[1]);
      if (arvalid || rready || araddr != 8'h00) rd_bad <= rd_bad + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int waited;
      int mx;
      logic [1:0] oh;
      oh = 2'b01 << v.grant;
      for (int k = 0; k < 2; k++) begin
         req_addr[k*8 +: 8]  = (k == v.grant) ? v.addr : (v.addr ^ 8'hFF);
         req_data[k*32 +: 32] = (k == v.grant) ? v.data : ~v.data;
         req_strb[k*4 +: 4]  = (k == v.grant) ? v.strb : ~v.strb;
      end
      req_valid = v.mask;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (req_ready_o == 2'b00 && waited < 20);
      chk({tag, "_ready"}, 32'(req_ready_o), 32'(oh));
      chk({tag, "_awvalid_on"}, 32'(awvalid), 32'd1);
      chk({tag, "_wvalid_on"}, 32'(wvalid), 32'd1);
      chk({tag, "_awaddr"}, 32'(awaddr), 32'(v.addr));
      chk({tag, "_wdata"}, wdata, v.data);
      chk({tag, "_wstrb"}, 32'(wstrb), 32'(v.strb));
      chk({tag, "_grant"}, 32'(grant_o), 32'(v.grant));
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (!v.hold) req_valid = 2'b00;
      mx = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
      for (int c = 0; c <= mx; c++) begin
         awready = (c == v.aw_dly);
         wready  = (c == v.w_dly);
         @(negedge clk);
         chk({tag, "_awvalid"}, 32'(awvalid), 32'(c < v.aw_dly));
         chk({tag, "_wvalid"}, 32'(wvalid), 32'(c < v.w_dly));
         if (c < v.w_dly) chk({tag, "_wdata_hold"}, wdata, v.data);
         if (c < v.aw_dly) chk({tag, "_awaddr_hold"}, 32'(awaddr), 32'(v.addr));
         chk({tag, "_bready"}, 32'(bready), 32'(c >= mx));
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int d = 0; d <= v.b_dly; d++) begin
         bvalid = (d == v.b_dly);
         bresp  = v.bresp;
         @(negedge clk);
         if (d < v.b_dly) begin
            chk({tag, "_rsp_wait"}, 32'(rsp_valid_o), 32'd0);
         end else begin
            chk({tag, "_rsp"}, 32'(rsp_valid_o), 32'(oh));
            chk({tag, "_err"}, 32'(rsp_err_o), 32'(v.err));
            chk({tag, "_bready_off"}, 32'(bready), 32'd0);
            chk({tag, "_idle"}, 32'(busy_o), 32'd0);
         end
      end
      bvalid = 1'b0;
      bresp  = 2'b00;
   endtask

   initial begin
      vecs[0] = '{2'b01, 1'b0, 0, 8'h04, 32'h0000_1000, 4'hF, 0, 0, 0, 2'b00, 1'b0};
      vecs[1] = '{2'b01, 1'b0, 0, 8'h08, 32'h0000_0002, 4'h3, 0, 4, 1, 2'b00, 1'b0};
      vecs[2] = '{2'b10, 1'b0, 1, 8'h10, 32'hDEAD_BEEF, 4'hF, 2, 0, 0, 2'b10, 1'b1};
      vecs[3] = '{2'b10, 1'b0, 1, 8'h14, 32'h1234_5678, 4'h1, 1, 1, 2, 2'b00, 1'b0};
      vecs[4] = '{2'b11, 1'b1, 0, 8'h20, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b11, 1'b1};
      vecs[5] = '{2'b11, 1'b1, 1, 8'h24, 32'hA5A5_0002, 4'hC, 0, 0, 0, 2'b00, 1'b0};
      vecs[6] = '{2'b11, 1'b1, 0, 8'h28, 32'hA5A5_0003, 4'hF, 0, 0, 0, 2'b01, 1'b1};
      vecs[7] = '{2'b11, 1'b0, 1, 8'h2C, 32'hA5A5_0004, 4'h8, 0, 0, 0, 2'b00, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp", 32'(rsp_valid_o), 32'd0);
      chk("rst_err", 32'(rsp_err_o), 32'd0);
      chk("rst_awaddr", 32'(awaddr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_wstrb", 32'(wstrb), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i], $sformatf("v%0d", i));
      end

      // Reset in the middle of a write to requester 1
      req_valid = 2'b10;
      begin
         int waited;
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (req_ready_o == 2'b00 && waited < 20);
      end
      chk("abort_pre_awvalid", 32'(awvalid), 32'd1);
      chk("abort_pre_grant", 32'(grant_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_awvalid", 32'(awvalid), 32'd0);
      chk("abort_wvalid", 32'(wvalid), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_ready", 32'(req_ready_o), 32'd0);
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_txn('{2'b11, 1'b0, 0, 8'h30, 32'h0BAD_F00D, 4'hF, 1, 0, 0, 2'b00, 1'b0}, "post_rst");

      repeat (3) @(negedge clk);
      chk("cnt_ready0", 32'(rdy_cnt0), 32'd5);
      chk("cnt_ready1", 32'(rdy_cnt1), 32'd5);
      chk("cnt_rsp0", 32'(rsp_cnt0), 32'd5);
      chk("cnt_rsp1", 32'(rsp_cnt1), 32'd4);
      chk("read_idle", 32'(rd_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
